// File: rtl/act_quant.sv
// Activation quantizer: per-lane ReLU, optional round-half-up, right shift and
// saturation to unsigned O_BW bits. Rounding is enabled by defining ACT_QUANT_ROUND_EN.
module act_quant #(
  parameter int AB_BW  = 21,
  parameter int O_BW   = 8,
  parameter int CNT_BW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [AB_BW*3-1:0]   i_acc_bias,
  input  logic [4:0]           i_shift,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [O_BW*3-1:0]    o_act,
  output logic [CNT_BW-1:0]    o_sat_cnt,
  input  logic                 i_clr_cnt
);

  // One extra bit of headroom so the rounding add on a max positive lane cannot wrap.
  localparam int W1 = AB_BW + 1;
  localparam logic [4:0] SH_MAX = 5'(AB_BW - 1);
  localparam logic signed [W1-1:0] OUT_MAX = W1'((1 << O_BW) - 1);
`ifdef ACT_QUANT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  function automatic logic signed [W1-1:0] relu_round(input logic signed [AB_BW-1:0] x,
                                                      input logic [4:0] sh);
    logic signed [W1-1:0] v;
    v = x[AB_BW-1] ? '0 : {1'b0, x};
    if (ROUND_EN && (sh != 5'd0))
      v = v + (W1'(1) << (sh - 5'd1));
    return v;
  endfunction

  // Returns {saturated, value}; the input is non-negative after ReLU.
  function automatic logic [O_BW:0] shift_sat(input logic signed [W1-1:0] v,
                                              input logic [4:0] sh);
    logic signed [W1-1:0] t;
    t = v >>> sh;
    return (t > OUT_MAX) ? {1'b1, {O_BW{1'b1}}} : (O_BW+1)'(t);
  endfunction

  logic                  vld_p1;
  logic signed [W1-1:0]  lane_p1 [3];
  logic [4:0]            shift_p1;
  logic                  vld_p2;
  logic                  sat_p2;
  logic [O_BW*3-1:0]     act_p2;
  logic [CNT_BW-1:0]     sat_cnt;

  logic                  adv_p1;
  logic                  adv_p2;
  logic                  xfer_out;
  logic [4:0]            shift_in;
  logic [O_BW*3-1:0]     act_nxt;
  logic [2:0]            lane_sat;

  assign adv_p2   = en & (~vld_p2 | i_ready);
  assign adv_p1   = en & (~vld_p1 | adv_p2);
  assign xfer_out = vld_p2 & i_ready & en;
  assign shift_in = (i_shift > SH_MAX) ? SH_MAX : i_shift;

  assign o_ready   = rst_n & adv_p1;
  assign o_valid   = vld_p2;
  assign o_act     = act_p2;
  assign o_sat_cnt = sat_cnt;

  // Stage 1: ReLU and rounding offset
  always_ff @(posedge clk) begin
    if (adv_p1 && i_valid) begin
      for (int i = 0; i < 3; i++)
        lane_p1[i] <= relu_round(i_acc_bias[i*AB_BW +: AB_BW], shift_in);
      shift_p1 <= shift_in;
    end
  end

  always_comb begin
    act_nxt  = '0;
    lane_sat = '0;
    for (int i = 0; i < 3; i++)
      {lane_sat[i], act_nxt[i*O_BW +: O_BW]} = shift_sat(lane_p1[i], shift_p1);
  end

  // Stage 2: shift and saturate, registered straight onto the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      sat_p2 <= 1'b0;
      act_p2 <= '0;
    end else begin
      if (adv_p1)
        vld_p1 <= i_valid;
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          act_p2 <= act_nxt;
          sat_p2 <= |lane_sat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (i_clr_cnt)
      sat_cnt <= '0;
    else if (xfer_out && sat_p2 && !(&sat_cnt))
      sat_cnt <= sat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_act_quant.sv
// Directed bench for act_quant: vector table plus hand-written pipeline sequences.
module tb_act_quant;

  localparam int AB = 21;
`ifdef ACT_QUANT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        i_valid;
  logic        o_ready;
  logic [62:0] i_acc_bias;
  logic [4:0]  i_shift;
  logic        o_valid;
  logic        i_ready;
  logic [23:0] o_act;
  logic [15:0] o_sat_cnt;
  logic        i_clr_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  act_quant dut (
    .clk(clk), .rst_n(rst_n), .en(en), .i_valid(i_valid), .o_ready(o_ready),
    .i_acc_bias(i_acc_bias), .i_shift(i_shift), .o_valid(o_valid),
    .i_ready(i_ready), .o_act(o_act), .o_sat_cnt(o_sat_cnt), .i_clr_cnt(i_clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a0, a1, a2;
    int sh;
    int e0, e1, e2;
    int sat;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int nb, input int base, input int st0, input int st1,
                            input bit en_stall);
    int q[$];
    int sent, recv, cyc;
    logic [23:0] prev_act;
    bit prev_hold, in_win, up, dn;
    sent = 0; recv = 0; cyc = 0; prev_hold = 0; prev_act = '0;
    while (recv < nb && cyc < 60) begin
      in_win     = (cyc >= st0) && (cyc <= st1);
      en         = en_stall ? !in_win : 1'b1;
      i_ready    = en_stall ? 1'b1 : !in_win;
      i_valid    = (sent < nb);
      i_acc_bias = {AB'(0), AB'(0), AB'(base + sent)};
      i_shift    = 5'd0;
      #1;
      if (prev_hold) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_act", o_act, prev_act);
      end
      if (in_win && en_stall) chk("en_low_ready", o_ready, 0);
      if (in_win && !en_stall && cyc > st0) chk("full_ready", o_ready, 0);
      up = i_valid & o_ready & en;
      dn = o_valid & i_ready & en;
      if (dn) begin
        if (q.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat_order", o_act, 64'(q.pop_front()));
        recv++;
      end
      if (up) begin
        q.push_back(base + sent);
        sent++;
      end
      prev_hold = o_valid & !dn;
      prev_act  = o_act;
      tick();
      cyc++;
    end
    chk("beats_out", recv, nb);
    en = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
  endtask

  initial begin
    vt[0] = '{16, -5, 100000, 2, 4, 0, 255, 1};
    vt[1] = '{9, 0, 0, 1, RND ? 5 : 4, 0, 0, 0};
    vt[2] = '{200, 255, 256, 0, 200, 255, 255, 1};
    vt[3] = '{-1, -1048576, 1048575, 31, 0, 0, RND ? 1 : 0, 0};
    vt[4] = '{1023, 1024, 1022, 2, 255, 255, 255, 1};
    vt[5] = '{7, 6, 5, 1, RND ? 4 : 3, 3, RND ? 3 : 2, 0};
    vt[6] = '{510, 511, 0, 1, 255, 255, 0, RND ? 1 : 0};
    vt[7] = '{300, -300, 40, 3, RND ? 38 : 37, 0, 5, 0};

    rst_n = 1'b0; en = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_acc_bias = '0; i_shift = '0; i_clr_cnt = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_act", o_act, 0);
    chk("rst_cnt", o_sat_cnt, 0);
    chk("rst_ready", o_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", o_ready, 1);
    tick();

    for (int k = 0; k < 8; k++) begin
      i_valid    = 1'b1;
      i_acc_bias = {AB'(vt[k].a2), AB'(vt[k].a1), AB'(vt[k].a0)};
      i_shift    = 5'(vt[k].sh);
      tick();
      i_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_valid", k), o_valid, 1);
      chk($sformatf("vec%0d_act", k), o_act,
          {8'(vt[k].e2), 8'(vt[k].e1), 8'(vt[k].e0)});
      tick();
      exp_cnt += vt[k].sat;
      chk($sformatf("vec%0d_cnt", k), o_sat_cnt, exp_cnt);
      chk($sformatf("vec%0d_drain", k), o_valid, 0);
    end

    run_stream(5, 10, 1, 3, 1'b0);
    run_stream(6, 40, 2, 3, 1'b1);

    i_clr_cnt = 1'b1; tick(); i_clr_cnt = 1'b0;
    chk("clr_cnt", o_sat_cnt, 0);
    i_acc_bias = {AB'(100000), AB'(0), AB'(0)};
    i_shift = 5'd0;
    for (int c = 0; c < 7; c++) begin
      i_valid   = (c < 4);
      i_clr_cnt = (c == 5);
      tick();
      if (c == 4) chk("cnt_three", o_sat_cnt, 3);
      if (c == 5) chk("clr_beats_inc", o_sat_cnt, 0);
    end
    i_clr_cnt = 1'b0;
    chk("cnt_after_clr", o_sat_cnt, 0);

    for (int c = 0; c < 65540; c++) begin
      i_valid = (c < 65537);
      tick();
    end
    chk("cnt_sticky", o_sat_cnt, 16'hFFFF);
    en = 1'b0; i_clr_cnt = 1'b1; tick();
    i_clr_cnt = 1'b0; en = 1'b1;
    chk("clr_with_en_low", o_sat_cnt, 0);

    i_ready = 1'b0; i_valid = 1'b1;
    i_acc_bias = {AB'(0), AB'(0), AB'(77)};
    tick(); tick();
    i_valid = 1'b0;
    chk("midrst_full", o_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_act", o_act, 0);
    chk("midrst_ready", o_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; i_ready = 1'b1;
    #1;
    chk("midrst_release_ready", o_ready, 1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("no_stale_beat", o_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/act_quant.md
ACT_QUANT -- requirements
Module: act_quant

Interface
REQ-001 SHALL have parameter AB_BW, default 21, meaning the signed two's-complement width of each input lane.
REQ-002 SHALL have parameter O_BW, default 8, meaning the unsigned width of each output lane.
REQ-003 SHALL have parameter CNT_BW, default 16, meaning the saturation-counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: global advance enable; 0 freezes the pipeline.
REQ-007 SHALL have port i_valid, input, 1 bit: upstream beat valid.
REQ-008 SHALL have port o_ready, output, 1 bit: block can accept an upstream beat.
REQ-009 SHALL have port i_acc_bias, input, AB_BW*3 bits: three biased accumulator lanes; lane0 = [AB_BW-1:0].
REQ-010 SHALL have port i_shift, input, 5 bits: right-shift amount, sampled with the beat.
REQ-011 SHALL have port o_valid, output, 1 bit: output beat valid.
REQ-012 SHALL have port i_ready, input, 1 bit: downstream can accept.
REQ-013 SHALL have port o_act, output, O_BW*3 bits: quantized activations, same lane order as i_acc_bias.
REQ-014 SHALL have port o_sat_cnt, output, CNT_BW bits: count of output beats with any saturated lane.
REQ-015 SHALL have port i_clr_cnt, input, 1 bit: synchronous clear of o_sat_cnt.

Function
REQ-016 SHALL transfer a beat upstream when i_valid & o_ready & en, and downstream when o_valid & i_ready & en.
REQ-017 SHALL implement two register stages: S1 (ReLU + rounding add), S2 (shift + saturate); S2 drives o_valid/o_act directly.
REQ-018 SHALL have latency 2 cycles from upstream transfer to o_valid, and sustain 1 beat/cycle when i_ready=1 and en=1.
REQ-019 SHALL advance S2 when en & (!s2_valid | i_ready); SHALL advance S1 when en & (!s1_valid | S2 advances).
REQ-020 SHALL drive o_ready combinationally as en & (!s1_valid | S2 advances); o_ready SHALL NOT depend on i_valid.
REQ-021 SHALL hold o_act and o_valid stable while o_valid=1 and i_ready=0, or while en=0.
REQ-022 SHALL apply ReLU per lane in S1: lanes with a negative value become 0.
REQ-023 SHALL clamp i_shift values above AB_BW-1 to AB_BW-1 at capture; the shift travels with its beat.
REQ-024 SHALL perform an arithmetic right shift per lane in S2, computed in AB_BW+1 bits so rounding cannot overflow.
REQ-025 SHALL saturate each shifted lane to 2^O_BW-1 (255) when it exceeds that value, and flag the lane saturated.
REQ-026 SHALL increment o_sat_cnt by 1 on each downstream transfer in which any lane saturated, sticking at all-ones.
REQ-027 SHALL give i_clr_cnt priority over increment in the same cycle (result 0); the clear SHALL act regardless of en.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force s1_valid=0, o_valid=0, o_act=0, o_sat_cnt=0, and o_ready=0.
REQ-029 SHALL discard in-flight beats when reset is asserted mid-operation; no partial beat SHALL emerge after release.
REQ-030 SHALL raise o_ready=1 on the first cycle after rst_n deasserts, provided en=1.

Configuration
REQ-031 SHALL support macro ACT_QUANT_ROUND_EN. When defined, S1 SHALL add 2^(shift-1) to each post-ReLU lane when shift>0 (round half up). When undefined, no add SHALL occur and the shift SHALL truncate. Ports and latency SHALL be identical in both builds.

Verification
REQ-032 SHALL cover basic quantization: lanes {16,-5,100000}, shift=2, i_ready=1 -> 2 cycles later o_act lanes {4,0,255}, o_sat_cnt=1.
REQ-033 SHALL cover rounding: lane0=9, shift=1 -> o_act lane0=5 with ACT_QUANT_ROUND_EN defined, 4 without; shift=0, lane0=200 -> 200 in both builds.
REQ-034 SHALL cover backpressure: stream 5 beats with i_ready=0 for 3 cycles -> o_act held; o_ready=0 once S1 and S2 are full; all 5 beats emerge in order, none lost or duplicated.
REQ-035 SHALL cover en: en=0 for 2 cycles mid-stream -> o_ready=0; the pipeline freezes; output resumes unchanged on en=1.
REQ-036 SHALL cover the counter: saturate 3 beats, then i_clr_cnt coincident with a 4th saturating transfer -> o_sat_cnt=0; preload to 0xFFFF stays at 0xFFFF.
REQ-037 SHALL cover reset mid-operation: assert rst_n=0 with both stages valid -> o_valid=0 and o_act=0 immediately; no stale beat appears after release.
